// File: rtl/nfu2_accum_cluster.sv
// nfu2_accum_cluster: Tn-lane reduce-and-accumulate unit.
// Each lane sums Tn signed N-bit elements through a registered pairwise adder
// tree (log2(Tn) levels). The tree output is then accumulated across a
// first..last sequence of beats. The result is held in o_res/o_valid until
// downstream takes it.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   i_vals            Tn lanes x Tn elements x N bits; element j of lane k
//                     is at [(k*Tn+j)*N +: N]
//   i_valid           i_vals / i_first / i_last are valid
//   i_first, i_last   beat opens / closes an accumulation
//   o_ready           beat accepted this cycle (combinational)
//   o_res             per-lane result; lane k is at [k*N +: N]
//   o_valid           o_res holds a result
//   i_ready           downstream takes the result
//   o_beats           beats summed into o_res (saturates at 255)
//   o_err             sticky protocol-error flag
//
// Build option: define NFU2_SATURATE_EN to clamp every add to the signed
// N-bit range instead of wrapping. Ports and latency are the same either way.
module nfu2_accum_cluster #(
    parameter int unsigned N  = 16,
    parameter int unsigned Tn = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [Tn*Tn*N-1:0] i_vals,
    input  logic               i_valid,
    input  logic               i_first,
    input  logic               i_last,
    output logic               o_ready,
    output logic [Tn*N-1:0]    o_res,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [7:0]         o_beats,
    output logic               o_err
);

    localparam int unsigned S  = $clog2(Tn);
    localparam int unsigned HT = Tn / 2;

    // N-bit add: wraps by default, clamps when saturation is enabled
    function automatic logic [N-1:0] add_n(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] s;
        s = a + b;
`ifdef NFU2_SATURATE_EN
        if ((a[N-1] == b[N-1]) && (s[N-1] != a[N-1]))
            s = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
        return s;
    endfunction

    // Level s-1 of the tree holds Tn>>s partial sums per lane; slots beyond
    // that are never loaded and stay at their reset value.
    logic [N-1:0]  node [S][Tn][HT];
    logic [S-1:0]  lvl_v;
    logic [S-1:0]  lvl_f;
    logic [S-1:0]  lvl_l;

    logic          acc_open;
    logic [Tn*N-1:0] acc;
    logic [7:0]    cnt;

    logic          start_c;
    logic          proto_err_c;
    logic [Tn*N-1:0] acc_nxt_c;
    logic [7:0]    cnt_nxt_c;

    // Upstream may advance whenever the output slot is empty or being drained
    assign o_ready = ~(o_valid & ~i_ready);

    // Adder tree; everything freezes while o_ready is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_v <= '0;
            lvl_f <= '0;
            lvl_l <= '0;
            for (int s = 0; s < S; s++)
                for (int k = 0; k < Tn; k++)
                    for (int j = 0; j < HT; j++)
                        node[s][k][j] <= '0;
        end else if (o_ready) begin
            lvl_v[0] <= i_valid;
            lvl_f[0] <= i_valid & i_first;
            lvl_l[0] <= i_valid & i_last;
            for (int k = 0; k < Tn; k++)
                for (int j = 0; j < HT; j++)
                    node[0][k][j] <= add_n(i_vals[(k*Tn + 2*j)*N +: N],
                                           i_vals[(k*Tn + 2*j + 1)*N +: N]);
            for (int s = 1; s < S; s++) begin
                lvl_v[s] <= lvl_v[s-1];
                lvl_f[s] <= lvl_f[s-1];
                lvl_l[s] <= lvl_l[s-1];
                for (int k = 0; k < Tn; k++)
                    for (int j = 0; j < (Tn >> (s + 1)); j++)
                        node[s][k][j] <= add_n(node[s-1][k][2*j], node[s-1][k][2*j+1]);
            end
        end
    end

    // Accumulate step: a stray non-first beat, or a first beat that lands on an
    // open accumulation, is flagged and then treated as a fresh start.
    always_comb begin
        start_c     = lvl_f[S-1] | ~acc_open;
        proto_err_c = (lvl_f[S-1] & acc_open) | (~lvl_f[S-1] & ~acc_open);
        acc_nxt_c   = '0;
        for (int k = 0; k < Tn; k++)
            acc_nxt_c[k*N +: N] = start_c ? node[S-1][k][0]
                                          : add_n(acc[k*N +: N], node[S-1][k][0]);
        if (start_c)
            cnt_nxt_c = 8'd1;
        else if (cnt == 8'hFF)
            cnt_nxt_c = cnt;
        else
            cnt_nxt_c = cnt + 8'd1;
    end

    // Accumulator and output slot; a new result may replace a drained one in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_open <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            o_res    <= '0;
            o_valid  <= 1'b0;
            o_beats  <= '0;
            o_err    <= 1'b0;
        end else if (o_ready) begin
            o_valid <= lvl_v[S-1] & lvl_l[S-1];
            if (lvl_v[S-1]) begin
                acc <= acc_nxt_c;
                cnt <= cnt_nxt_c;
                if (proto_err_c)
                    o_err <= 1'b1;
                if (lvl_l[S-1]) begin
                    acc_open <= 1'b0;
                    o_res    <= acc_nxt_c;
                    o_beats  <= cnt_nxt_c;
                end else begin
                    acc_open <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nfu2_accum_cluster.sv
// Directed bench for nfu2_accum_cluster (N=16, Tn=16).
// Beats drive every element of lane k to val + step*k. Expected lane k of a
// result is exp0 + slope*k, with exp0 and slope worked out by hand below.
module tb_nfu2_accum_cluster;

    localparam int unsigned N  = 16;
    localparam int unsigned TN = 16;
    localparam int unsigned LW = TN * N;
    localparam int unsigned IW = TN * TN * N;
    localparam int unsigned NV = 10;

    typedef struct {
        logic [N-1:0] val;
        logic [N-1:0] step;
        logic         first;
        logic         last;
        logic [N-1:0] exp0;
        logic [N-1:0] slope;
        logic [7:0]   beats;
    } vec_t;

    typedef struct {
        logic [LW-1:0] res;
        logic [7:0]    beats;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] i_vals = '0;
    logic          i_valid = 1'b0;
    logic          i_first = 1'b0;
    logic          i_last = 1'b0;
    logic          o_ready;
    logic [LW-1:0] o_res;
    logic          o_valid;
    logic          i_ready = 1'b1;
    logic [7:0]    o_beats;
    logic          o_err;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    vec_t tbl [NV];

    always #5 clk = ~clk;

    nfu2_accum_cluster #(.N(N), .Tn(TN)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_vals  (i_vals),
        .i_valid (i_valid),
        .i_first (i_first),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_res   (o_res),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_beats (o_beats),
        .o_err   (o_err)
    );

    function automatic logic [IW-1:0] mk_vals(input logic [N-1:0] val, input logic [N-1:0] step);
        logic [IW-1:0] v;
        v = '0;
        for (int k = 0; k < TN; k++)
            for (int j = 0; j < TN; j++)
                v[(k*TN + j)*N +: N] = N'(val + step * N'(k));
        return v;
    endfunction

    function automatic logic [LW-1:0] mk_res(input logic [N-1:0] exp0, input logic [N-1:0] slope);
        logic [LW-1:0] r;
        r = '0;
        for (int k = 0; k < TN; k++)
            r[k*N +: N] = N'(exp0 + slope * N'(k));
        return r;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock: score any result taken at the coming edge, then step past it
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (o_valid && i_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h required=none", o_res);
            end else begin
                e = q.pop_front();
                chk("res", o_res, e.res);
                chk("beats", LW'(o_beats), LW'(e.beats));
                chk("err", LW'(o_err), LW'(e.err));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N-1:0] exp0, input logic [N-1:0] slope,
                        input logic [7:0] beats, input logic err);
        exp_t e;
        e.res   = mk_res(exp0, slope);
        e.beats = beats;
        e.err   = err;
        q.push_back(e);
    endtask

    // Drive one accepted beat, then park junk on the idle cycle that must be ignored
    task automatic beat(input logic [N-1:0] val, input logic [N-1:0] step,
                        input logic first, input logic last);
        i_vals  = mk_vals(val, step);
        i_first = first;
        i_last  = last;
        i_valid = 1'b1;
        chk("accept", LW'(o_ready), LW'(1'b1));
        tick();
        i_valid = 1'b0;
        i_first = 1'b1;
        i_last  = 1'b1;
        i_vals  = '1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++)
            tick();
        repeat (8) tick();
        chk("drain", LW'(q.size()), '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_res", o_res, '0);
        chk("rst_valid", LW'(o_valid), '0);
        chk("rst_beats", LW'(o_beats), '0);
        chk("rst_err", LW'(o_err), '0);
        chk("rst_ready", LW'(o_ready), LW'(1'b1));
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        // val, step, first, last, exp0, slope, beats
        tbl[0] = '{16'd1,      16'd0, 1'b1, 1'b1, 16'd16,   16'd0,  8'd1};  // 16 x 1
        tbl[1] = '{16'd1,      16'd0, 1'b1, 1'b0, 16'd0,    16'd0,  8'd0};
        tbl[2] = '{16'd2,      16'd0, 1'b0, 1'b0, 16'd0,    16'd0,  8'd0};
        tbl[3] = '{16'd3,      16'd0, 1'b0, 1'b1, 16'd96,   16'd0,  8'd3};  // 16+32+48
        tbl[4] = '{16'd5,      16'd1, 1'b1, 1'b1, 16'd80,   16'd16, 8'd1};  // 16*(5+k)
        tbl[5] = '{16'hFFFD,   16'd0, 1'b1, 1'b0, 16'd0,    16'd0,  8'd0};
        tbl[6] = '{16'd1,      16'd1, 1'b0, 1'b1, 16'hFFE0, 16'd16, 8'd2};  // -48 + 16*(1+k)
        tbl[7] = '{16'd7,      16'd0, 1'b1, 1'b1, 16'd112,  16'd0,  8'd1};
        tbl[8] = '{16'd2,      16'd2, 1'b1, 1'b1, 16'd32,   16'd32, 8'd1};  // back-to-back with row 7
`ifdef NFU2_SATURATE_EN
        tbl[9] = '{16'h7FFF,   16'd0, 1'b1, 1'b1, 16'h7FFF, 16'd0,  8'd1};
`else
        tbl[9] = '{16'h7FFF,   16'd0, 1'b1, 1'b1, 16'hFFF0, 16'd0,  8'd1};  // 16*0x7FFF = 0x7FFF0
`endif

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < NV; i++) begin
            beat(tbl[i].val, tbl[i].step, tbl[i].first, tbl[i].last);
            if (tbl[i].last)
                push(tbl[i].exp0, tbl[i].slope, tbl[i].beats, 1'b0);
        end
        drain();

        // Stall: hold the first result for 4 cycles while a second waits in the tree
        i_ready = 1'b0;
        beat(16'd4, 16'd0, 1'b1, 1'b1);
        push(16'd64, 16'd0, 8'd1, 1'b0);
        beat(16'd6, 16'd0, 1'b1, 1'b1);
        push(16'd96, 16'd0, 8'd1, 1'b0);
        for (int i = 0; i < 20 && !o_valid; i++)
            tick();
        chk("stall_valid", LW'(o_valid), LW'(1'b1));
        for (int i = 0; i < 4; i++) begin
            chk("stall_ready", LW'(o_ready), '0);
            chk("stall_hold", o_res, mk_res(16'd64, 16'd0));
            tick();
        end
        i_ready = 1'b1;
        drain();

        // Reset in the middle of a three-beat accumulation
        beat(16'd1, 16'd0, 1'b1, 1'b0);
        beat(16'd2, 16'd0, 1'b0, 1'b0);
        do_reset();
        beat(16'd3, 16'd0, 1'b1, 1'b1);
        push(16'd48, 16'd0, 8'd1, 1'b0);
        drain();

        // Non-first beat after reset: flagged, summed as a fresh start
        do_reset();
        beat(16'd2, 16'd1, 1'b0, 1'b1);
        push(16'd32, 16'd16, 8'd1, 1'b1);
        drain();

        // First beat landing on an open accumulation restarts it
        beat(16'd1, 16'd0, 1'b1, 1'b0);
        beat(16'd2, 16'd0, 1'b1, 1'b1);
        push(16'd32, 16'd0, 8'd1, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
